// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with the ID/EX register, one-hot ALU, data-SRAM request and a 32-step divider.
// Define EX_MUL_EN to enable single-cycle MULT/MULTU; by default MULT/MULTU execute as NOPs.
module ex_stage #(
   parameter int ID_TO_EX_WD  = 159,
   parameter int EX_TO_MEM_WD = 76,
   parameter int DIV_ITER     = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [5:0]              stall,
   input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
   output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   output logic [37:0]             ex_to_rf_bus,
   output logic                    ex_is_load,
   output logic [64:0]             ex_hilo_bus,
   output logic                    stallreq_for_ex,
   output logic                    data_sram_en,
   output logic [3:0]              data_sram_wen,
   output logic [31:0]             data_sram_addr,
   output logic [31:0]             data_sram_wdata
);

   localparam int CNT_W = $clog2(DIV_ITER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   function automatic logic [31:0] neg32(input logic [31:0] x);
      return 32'd0 - x;
   endfunction

   logic [ID_TO_EX_WD-1:0] bus_q, bus_d;

   logic [31:0] pc_s, inst_s, rs_data_s, rt_data_s;
   logic [11:0] alu_op_s;
   logic [2:0]  sel_src1_s;
   logic [3:0]  sel_src2_s;
   logic        ram_en_s, rf_we_s, sel_rf_res_s, valid_s;
   logic [3:0]  ram_wen_s;
   logic [4:0]  rf_waddr_s;
   logic [5:0]  opcode_s, func_s;

   logic [31:0] src1_s, src2_s, alu_res_s;
   logic [31:0] add_s, sub_s, slt_s, sltu_s, and_s, nor_s, or_s, xor_s;
   logic [31:0] sll_s, srl_s, sra_s, lui_s;

   div_state_e  div_state_q, div_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0] quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
   logic        sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
   logic        is_div_s, div_signed_s, a_neg_s, b_neg_s, stallreq_s;
   logic [31:0] abs_a_s, abs_b_s, quo_fix_s, rem_fix_s, lo_s;
   logic [32:0] rem_shift_s, rem_diff_s;
   logic [64:0] mul_hilo_s;
   logic        unused_s;

   assign pc_s         = bus_q[158:127];
   assign inst_s       = bus_q[126:95];
   assign alu_op_s     = bus_q[94:83];
   assign sel_src1_s   = bus_q[82:80];
   assign sel_src2_s   = bus_q[79:76];
   assign ram_en_s     = bus_q[75];
   assign ram_wen_s    = bus_q[74:71];
   assign rf_we_s      = bus_q[70];
   assign rf_waddr_s   = bus_q[69:65];
   assign sel_rf_res_s = bus_q[64];
   assign rs_data_s    = bus_q[63:32];
   assign rt_data_s    = bus_q[31:0];
   assign opcode_s     = inst_s[31:26];
   assign func_s       = inst_s[5:0];

   // A cleared bus (PC=0) is a bubble: every output below is forced to zero for it.
   assign valid_s  = |pc_s;
   assign unused_s = ^{stall[5:4], stall[1:0], inst_s[25:16]};

   // ID/EX next state: bubble when ID stops but EX moves, load when ID moves, otherwise hold.
   always_comb begin
      bus_d = bus_q;
      if (stall[2] && !stall[3]) begin
         bus_d = '0;
      end else if (!stall[2]) begin
         bus_d = id_to_ex_bus;
      end else begin
         bus_d = bus_q;
      end
   end

   // Operand selects are AND-OR so an empty select yields zero.
   assign src1_s = ({32{sel_src1_s[0]}} & rs_data_s)
                 | ({32{sel_src1_s[1]}} & pc_s)
                 | ({32{sel_src1_s[2]}} & {27'd0, inst_s[10:6]});
   assign src2_s = ({32{sel_src2_s[0]}} & rt_data_s)
                 | ({32{sel_src2_s[1]}} & {{16{inst_s[15]}}, inst_s[15:0]})
                 | ({32{sel_src2_s[2]}} & 32'd8)
                 | ({32{sel_src2_s[3]}} & {16'd0, inst_s[15:0]});

   assign add_s  = src1_s + src2_s;
   assign sub_s  = src1_s - src2_s;
   assign slt_s  = {31'd0, ($signed(src1_s) < $signed(src2_s))};
   assign sltu_s = {31'd0, (src1_s < src2_s)};
   assign and_s  = src1_s & src2_s;
   assign nor_s  = ~(src1_s | src2_s);
   assign or_s   = src1_s | src2_s;
   assign xor_s  = src1_s ^ src2_s;
   assign sll_s  = src2_s << src1_s[4:0];
   assign srl_s  = src2_s >> src1_s[4:0];
   assign sra_s  = $signed(src2_s) >>> src1_s[4:0];
   assign lui_s  = {src2_s[15:0], 16'd0};

   assign alu_res_s = ({32{alu_op_s[11]}} & add_s)  | ({32{alu_op_s[10]}} & sub_s)
                    | ({32{alu_op_s[9]}}  & slt_s)  | ({32{alu_op_s[8]}}  & sltu_s)
                    | ({32{alu_op_s[7]}}  & and_s)  | ({32{alu_op_s[6]}}  & nor_s)
                    | ({32{alu_op_s[5]}}  & or_s)   | ({32{alu_op_s[4]}}  & xor_s)
                    | ({32{alu_op_s[3]}}  & sll_s)  | ({32{alu_op_s[2]}}  & srl_s)
                    | ({32{alu_op_s[1]}}  & sra_s)  | ({32{alu_op_s[0]}}  & lui_s);

   assign ex_to_mem_bus   = valid_s ? {pc_s, ram_en_s, ram_wen_s, sel_rf_res_s, rf_we_s, rf_waddr_s, alu_res_s}
                                    : {EX_TO_MEM_WD{1'b0}};
   assign ex_to_rf_bus    = valid_s ? {rf_we_s, rf_waddr_s, alu_res_s} : 38'd0;
   assign ex_is_load      = valid_s & ram_en_s & sel_rf_res_s;
   assign data_sram_en    = valid_s & ram_en_s;
   assign data_sram_wen   = valid_s ? {4{|ram_wen_s}} : 4'd0;
   assign data_sram_addr  = valid_s ? alu_res_s : 32'd0;
   assign data_sram_wdata = valid_s ? rt_data_s : 32'd0;

   assign is_div_s     = valid_s && (opcode_s == 6'd0) && ((func_s == 6'h1A) || (func_s == 6'h1B));
   assign div_signed_s = (func_s == 6'h1A);
   assign a_neg_s      = div_signed_s & rs_data_s[31];
   assign b_neg_s      = div_signed_s & rt_data_s[31];
   assign abs_a_s      = a_neg_s ? neg32(rs_data_s) : rs_data_s;
   assign abs_b_s      = b_neg_s ? neg32(rt_data_s) : rt_data_s;

   // Restoring step: remainder picks up the next dividend bit, subtract when it fits.
   assign rem_shift_s  = {rem_q, quo_q[31]};
   assign rem_diff_s   = rem_shift_s - {1'b0, dsr_q};

   assign quo_fix_s = (sa_q ^ sb_q) ? neg32(quo_q) : quo_q;
   assign rem_fix_s = sa_q ? neg32(rem_q) : rem_q;
   assign lo_s      = dz_q ? 32'hFFFF_FFFF : quo_fix_s;

   // Divider FSM next state and stall request.
   always_comb begin
      div_state_d = div_state_q;
      cnt_d       = cnt_q;
      quo_d       = quo_q;
      rem_d       = rem_q;
      dsr_d       = dsr_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      dz_d        = dz_q;
      stallreq_s  = 1'b0;
      case (div_state_q)
         DIV_IDLE: begin
            if (is_div_s) begin
               quo_d       = abs_a_s;
               rem_d       = 32'd0;
               dsr_d       = abs_b_s;
               sa_d        = a_neg_s;
               sb_d        = b_neg_s;
               dz_d        = (rt_data_s == 32'd0);
               cnt_d       = '0;
               stallreq_s  = 1'b1;
               div_state_d = DIV_RUN;
            end else begin
               div_state_d = DIV_IDLE;
            end
         end
         DIV_RUN: begin
            stallreq_s = 1'b1;
            if (!rem_diff_s[32]) begin
               rem_d = rem_diff_s[31:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = rem_shift_s[31:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            if (cnt_q == CNT_LAST) begin
               div_state_d = DIV_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DIV_DONE: begin
            if (!stall[3]) begin
               div_state_d = DIV_IDLE;
            end else begin
               div_state_d = DIV_DONE;
            end
         end
         default: begin
            div_state_d = DIV_IDLE;
         end
      endcase
   end

`ifdef EX_MUL_EN
   logic        is_mult_s, mul_signed_s;
   logic [63:0] mul_a_s, mul_b_s, prod_s;

   assign is_mult_s    = valid_s && (opcode_s == 6'd0) && ((func_s == 6'h18) || (func_s == 6'h19));
   assign mul_signed_s = (func_s == 6'h18);
   assign mul_a_s      = {(mul_signed_s ? {32{rs_data_s[31]}} : 32'd0), rs_data_s};
   assign mul_b_s      = {(mul_signed_s ? {32{rt_data_s[31]}} : 32'd0), rt_data_s};
   assign prod_s       = mul_a_s * mul_b_s;
   assign mul_hilo_s   = is_mult_s ? {1'b1, prod_s} : 65'd0;
`else
   assign mul_hilo_s   = 65'd0;
`endif

   assign ex_hilo_bus     = (div_state_q == DIV_DONE) ? {1'b1, rem_fix_s, lo_s} : mul_hilo_s;
   assign stallreq_for_ex = stallreq_s;

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_q       <= '0;
         div_state_q <= DIV_IDLE;
         cnt_q       <= '0;
         quo_q       <= 32'd0;
         rem_q       <= 32'd0;
         dsr_q       <= 32'd0;
         sa_q        <= 1'b0;
         sb_q        <= 1'b0;
         dz_q        <= 1'b0;
      end else begin
         bus_q       <= bus_d;
         div_state_q <= div_state_d;
         cnt_q       <= cnt_d;
         quo_q       <= quo_d;
         rem_q       <= rem_d;
         dsr_q       <= dsr_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         dz_q        <= dz_d;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed vector bench for ex_stage: ALU/SRAM table plus hand-written divider, stall and reset sequences.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [158:0] id_bus;
   logic [75:0] ex_to_mem_bus;
   logic [37:0] ex_to_rf_bus;
   logic        ex_is_load;
   logic [64:0] ex_hilo_bus;
   logic        stallreq_for_ex;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;

   int n_total = 0;
   int n_pass  = 0;

   ex_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .id_to_ex_bus    (id_bus),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .ex_to_rf_bus    (ex_to_rf_bus),
      .ex_is_load      (ex_is_load),
      .ex_hilo_bus     (ex_hilo_bus),
      .stallreq_for_ex (stallreq_for_ex),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [11:0] op;
      logic [2:0]  s1;
      logic [3:0]  s2;
      logic        ren;
      logic [3:0]  rwen;
      logic        rfwe;
      logic [4:0]  wa;
      logic        sel;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] res;
      logic        en;
      logic [3:0]  wen;
      logic [31:0] wdata;
      logic        ld;
      logic        vld;
   } vec_t;

   localparam int NV = 21;
   localparam logic [31:0] P = 32'hBFC0_0040;
   vec_t vecs [NV];

   logic [37:0] exp_rf;
   logic [75:0] exp_mem;
   logic [31:0] exp_addr;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [158:0] build(input vec_t v);
      return {v.pc, v.inst, v.op, v.s1, v.s2, v.ren, v.rwen, v.rfwe, v.wa, v.sel, v.rs, v.rt};
   endfunction

   function automatic logic [158:0] rtype(input logic [5:0] func, input logic [31:0] a, input logic [31:0] b);
      return {32'hBFC0_0100, {6'd0, 5'd8, 5'd9, 10'd0, func}, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0,
              1'b0, 5'd0, 1'b0, a, b};
   endfunction

   task automatic run_div(input string nm, input logic [5:0] func, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi);
      int  n;
      logic early_we;
      stall  = 6'b000000;
      id_bus = rtype(func, a, b);
      tick();
      stall  = 6'b001111;
      id_bus = '0;
      n = 0;
      early_we = 1'b0;
      while (stallreq_for_ex && n < 100) begin
         if (ex_hilo_bus[64]) early_we = 1'b1;
         n++;
         tick();
      end
      chk({nm, " stall_cycles"}, n, 33);
      chk({nm, " hilo"}, ex_hilo_bus, {1'b1, hi, lo});
      chk({nm, " no_early_we"}, early_we, 1'b0);
      stall = 6'b000000;
      tick();
      chk({nm, " we_one_cycle"}, ex_hilo_bus[64], 1'b0);
   endtask

   initial begin
      //            pc            inst          op      s1      s2       ren   rwen  rfwe  wa     sel   rs            rt            res           en    wen   wdata         ld    vld
      vecs[0]  = '{P,            32'h2422_FFFF, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd2,  1'b0, 32'd5,        32'd0,        32'd4,        1'b0, 4'h0, 32'd0,        1'b0, 1'b1};
      vecs[1]  = '{P,            32'h0003_2100, 12'h008, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4,  1'b0, 32'h1234_5678, 32'h1,       32'h10,       1'b0, 4'h0, 32'h1,        1'b0, 1'b1};
      vecs[2]  = '{P,            32'h0022_182A, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3,  1'b0, 32'hFFFF_FFFF, 32'h1,       32'h1,        1'b0, 4'h0, 32'h1,        1'b0, 1'b1};
      vecs[3]  = '{P,            32'h0022_182B, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3,  1'b0, 32'hFFFF_FFFF, 32'h1,       32'h0,        1'b0, 4'h0, 32'h1,        1'b0, 1'b1};
      vecs[4]  = '{P,            32'h3C01_1234, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd1,  1'b0, 32'd0,        32'd0,        32'h1234_0000, 1'b0, 4'h0, 32'd0,       1'b0, 1'b1};
      vecs[5]  = '{32'hBFC0_0000, 32'h0C00_0010, 12'h800, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'd0,        32'd0,        32'hBFC0_0008, 1'b0, 4'h0, 32'd0,       1'b0, 1'b1};
      vecs[6]  = '{P,            32'hAD09_0008, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0,  1'b0, 32'h100,      32'hDEAD,     32'h108,      1'b1, 4'hF, 32'hDEAD,     1'b0, 1'b1};
      vecs[7]  = '{P,            32'h8D0A_0004, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd10, 1'b1, 32'h100,      32'h55,       32'h104,      1'b1, 4'h0, 32'h55,       1'b1, 1'b1};
      vecs[8]  = '{P,            32'hA109_0003, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h1, 1'b0, 5'd0,  1'b0, 32'h200,      32'hAB,       32'h203,      1'b1, 4'hF, 32'hAB,       1'b0, 1'b1};
      vecs[9]  = '{P,            32'h0022_2823, 12'h400, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5,  1'b0, 32'd5,        32'd7,        32'hFFFF_FFFE, 1'b0, 4'h0, 32'd7,       1'b0, 1'b1};
      vecs[10] = '{P,            32'h0022_2824, 12'h080, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 4'h0, 32'hFF00_FF00, 1'b0, 1'b1};
      vecs[11] = '{P,            32'h0022_2827, 12'h040, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 4'h0, 32'hFF00_FF00, 1'b0, 1'b1};
      vecs[12] = '{P,            32'h0022_2825, 12'h020, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 4'h0, 32'hFF00_FF00, 1'b0, 1'b1};
      vecs[13] = '{P,            32'h0022_2826, 12'h010, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 4'h0, 32'hFF00_FF00, 1'b0, 1'b1};
      vecs[14] = '{P,            32'h0003_2102, 12'h004, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4,  1'b0, 32'd0,        32'h8000_0000, 32'h0800_0000, 1'b0, 4'h0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[15] = '{P,            32'h0003_2103, 12'h002, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4,  1'b0, 32'd0,        32'h8000_0000, 32'hF800_0000, 1'b0, 4'h0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[16] = '{P,            32'h0022_2820, 12'h000, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd6,  1'b0, 32'd5,        32'd7,        32'd0,        1'b0, 4'h0, 32'd7,        1'b0, 1'b1};
      vecs[17] = '{32'd0,        32'h2422_FFFF, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b1, 5'd2,  1'b1, 32'd5,        32'd9,        32'd0,        1'b0, 4'h0, 32'd0,        1'b0, 1'b0};
      vecs[18] = '{P,            32'h0000_0000, 12'h800, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd7,  1'b0, 32'd5,        32'd7,        32'd0,        1'b0, 4'h0, 32'd7,        1'b0, 1'b1};
      vecs[19] = '{P,            32'h3401_8000, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd1,  1'b0, 32'd1,        32'd0,        32'h0000_8001, 1'b0, 4'h0, 32'd0,       1'b0, 1'b1};
      vecs[20] = '{P,            32'h2401_8000, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd1,  1'b0, 32'd0,        32'd0,        32'hFFFF_8000, 1'b0, 4'h0, 32'd0,       1'b0, 1'b1};

      rst    = 1'b1;
      stall  = 6'b000000;
      id_bus = build(vecs[0]);
      tick();
      tick();
      chk("reset mem_bus", ex_to_mem_bus, 76'd0);
      chk("reset rf_bus", ex_to_rf_bus, 38'd0);
      chk("reset sram_en", data_sram_en, 1'b0);
      chk("reset stallreq", stallreq_for_ex, 1'b0);
      chk("reset hilo", ex_hilo_bus, 65'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         stall  = 6'b000000;
         id_bus = build(vecs[i]);
         tick();
         exp_rf   = vecs[i].vld ? {vecs[i].rfwe, vecs[i].wa, vecs[i].res} : 38'd0;
         exp_mem  = vecs[i].vld ? {vecs[i].pc, vecs[i].ren, vecs[i].rwen, vecs[i].sel, vecs[i].rfwe,
                                   vecs[i].wa, vecs[i].res} : 76'd0;
         exp_addr = vecs[i].vld ? vecs[i].res : 32'd0;
         chk($sformatf("rf_bus[%0d]", i), ex_to_rf_bus, exp_rf);
         chk($sformatf("mem_bus[%0d]", i), ex_to_mem_bus, exp_mem);
         chk($sformatf("sram_en[%0d]", i), data_sram_en, vecs[i].en);
         chk($sformatf("sram_wen[%0d]", i), data_sram_wen, vecs[i].wen);
         chk($sformatf("sram_addr[%0d]", i), data_sram_addr, exp_addr);
         chk($sformatf("sram_wdata[%0d]", i), data_sram_wdata, vecs[i].wdata);
         chk($sformatf("is_load[%0d]", i), ex_is_load, vecs[i].ld);
         chk($sformatf("stallreq[%0d]", i), stallreq_for_ex, 1'b0);
      end

      // EX holds on stall[3]=Stop, then takes a bubble on stall[2]=Stop, stall[3]=NoStop.
      stall  = 6'b000000;
      id_bus = build(vecs[0]);
      tick();
      stall  = 6'b001111;
      id_bus = build(vecs[1]);
      tick();
      chk("hold rf_bus", ex_to_rf_bus, {1'b1, 5'd2, 32'd4});
      stall = 6'b000111;
      tick();
      chk("bubble rf_bus", ex_to_rf_bus, 38'd0);
      chk("bubble mem_bus", ex_to_mem_bus, 76'd0);
      chk("bubble sram_en", data_sram_en, 1'b0);

      run_div("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_div("div_7_m2", 6'h1A, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
      run_div("div_min_m1", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
      run_div("divu_big_10", 6'h1B, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 32'd5);

      // Reset in the middle of a divide discards it.
      stall  = 6'b000000;
      id_bus = rtype(6'h1A, 32'd100, 32'd3);
      tick();
      stall  = 6'b001111;
      id_bus = '0;
      for (int k = 0; k < 11; k++) tick();
      chk("mid_run stallreq", stallreq_for_ex, 1'b1);
      rst = 1'b1;
      tick();
      chk("rst_run stallreq", stallreq_for_ex, 1'b0);
      chk("rst_run hilo", ex_hilo_bus, 65'd0);
      chk("rst_run mem_bus", ex_to_mem_bus, 76'd0);
      rst   = 1'b0;
      stall = 6'b000000;
      tick();
      chk("post_rst stallreq", stallreq_for_ex, 1'b0);

      run_div("divu_7_0", 6'h1B, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7);

      stall  = 6'b000000;
      id_bus = rtype(6'h18, 32'hFFFF_FFFD, 32'd5);
      tick();
`ifdef EX_MUL_EN
      chk("mult hilo", ex_hilo_bus, {1'b1, 64'hFFFF_FFFF_FFFF_FFF1});
`else
      chk("mult hilo", ex_hilo_bus, 65'd0);
`endif
      chk("mult stallreq", stallreq_for_ex, 1'b0);
      id_bus = rtype(6'h19, 32'hFFFF_FFFF, 32'd2);
      tick();
`ifdef EX_MUL_EN
      chk("multu hilo", ex_hilo_bus, {1'b1, 64'h0000_0001_FFFF_FFFE});
`else
      chk("multu hilo", ex_hilo_bus, 65'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
